// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: sequencer for an iterative AES-128 decrypt datapath.
//
// One shared inverse-round unit, the key-expansion unit and the final inverse
// sub/shift/key-add stage are stepped by this controller. It holds no datapath
// registers. It only issues enables, the round constant and the round-key
// slice select.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   key_valid/key_ready  key handshake (key itself lives on the datapath bus)
//   kexp_start           one-cycle pulse starting key expansion
//   kexp_done            key expansion finished (level or pulse)
//   kexp_err             sticky: key expansion timed out
//   in_valid/in_ready    ciphertext block handshake
//   dp_load_init         datapath loads state ^ key[NUM_ROUNDS-1]
//   dp_round_en          inverse-round register advances
//   dp_final_en          final stage result captured
//   rc, key_idx          round constant / round-key slice select
//   out_valid/out_ready  plaintext handshake
//   busy                 controller not idle
//   perf_blocks          (AES_DEC_PERF_COUNT_EN only) delivered block count
//   perf_stall           (AES_DEC_PERF_COUNT_EN only) saturating output stall count
//
// Optional feature macro: AES_DEC_PERF_COUNT_EN adds the two perf counters.
//
// All outputs except in_ready are registers decoded from the next state, so
// they are Moore outputs with no input-to-output paths. in_ready additionally
// gates on key_valid so a pending key wins over a block in the same cycle.

module aes_dec_round_ctrl #(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned KEXP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  output logic        key_ready,
  output logic        kexp_start,
  input  logic        kexp_done,
  output logic        kexp_err,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        dp_load_init,
  output logic        dp_round_en,
  output logic        dp_final_en,
  output logic [3:0]  rc,
  output logic [3:0]  key_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
`ifdef AES_DEC_PERF_COUNT_EN
  ,
  output logic [31:0] perf_blocks,
  output logic [15:0] perf_stall
`endif
);

  localparam logic [3:0] LastIdx     = 4'(NUM_ROUNDS - 1);
  localparam logic [7:0] TimeoutLast = 8'(KEXP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StKexp,
    StInit,
    StRound,
    StFinal,
    StOutv
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        key_loaded_q, key_loaded_d;
  logic        kexp_err_d;
  logic        in_rdy_q;

  // Registered output next values.
  logic        key_ready_d, in_rdy_d, kexp_start_d, busy_d;
  logic        load_init_d, round_en_d, final_en_d, out_valid_d;
  logic [3:0]  rc_d, key_idx_d;

  logic        key_acc, blk_acc, out_acc;

  assign in_ready = in_rdy_q & ~key_valid;
  assign key_acc  = key_valid & key_ready;
  assign blk_acc  = in_valid & in_ready;
  assign out_acc  = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tcnt_d       = tcnt_q;
    key_loaded_d = key_loaded_q;
    kexp_err_d   = kexp_err;

    unique case (state_q)
      StIdle: begin
        if (key_acc) begin
          state_d      = StKexp;
          kexp_err_d   = 1'b0;
          key_loaded_d = 1'b0;
          tcnt_d       = 8'd0;
        end else if (blk_acc) begin
          state_d = StInit;
        end
      end
      StKexp: begin
        // Done is tested first so it wins over a simultaneous timeout.
        if (kexp_done) begin
          key_loaded_d = 1'b1;
          state_d      = StIdle;
        end else if (tcnt_q >= TimeoutLast) begin
          kexp_err_d = 1'b1;
          state_d    = StIdle;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StInit: begin
        cnt_d   = LastIdx;
        state_d = StRound;
      end
      StRound: begin
        // Counter stops at 1; it never wraps.
        if (cnt_q <= 4'd1) begin
          state_d = StFinal;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StFinal: begin
        state_d = StOutv;
      end
      StOutv: begin
        if (out_acc) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Moore decode of the state being entered.
    key_ready_d  = (state_d == StIdle);
    in_rdy_d     = (state_d == StIdle) & key_loaded_d;
    kexp_start_d = key_acc;
    busy_d       = (state_d != StIdle);
    load_init_d  = (state_d == StInit);
    round_en_d   = (state_d == StRound);
    final_en_d   = (state_d == StFinal);
    out_valid_d  = (state_d == StOutv);
    rc_d         = 4'd0;
    key_idx_d    = 4'd0;
    unique case (state_d)
      StInit:  key_idx_d = LastIdx;
      StRound: begin
        rc_d      = cnt_d;
        key_idx_d = cnt_d - 4'd1;
      end
      StFinal: key_idx_d = LastIdx;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      tcnt_q       <= 8'd0;
      key_loaded_q <= 1'b0;
      kexp_err     <= 1'b0;
      in_rdy_q     <= 1'b0;
      key_ready    <= 1'b0;
      kexp_start   <= 1'b0;
      busy         <= 1'b0;
      dp_load_init <= 1'b0;
      dp_round_en  <= 1'b0;
      dp_final_en  <= 1'b0;
      out_valid    <= 1'b0;
      rc           <= 4'd0;
      key_idx      <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      key_loaded_q <= key_loaded_d;
      kexp_err     <= kexp_err_d;
      in_rdy_q     <= in_rdy_d;
      key_ready    <= key_ready_d;
      kexp_start   <= kexp_start_d;
      busy         <= busy_d;
      dp_load_init <= load_init_d;
      dp_round_en  <= round_en_d;
      dp_final_en  <= final_en_d;
      out_valid    <= out_valid_d;
      rc           <= rc_d;
      key_idx      <= key_idx_d;
    end
  end

`ifdef AES_DEC_PERF_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_blocks <= 32'd0;
      perf_stall  <= 16'd0;
    end else if (key_acc) begin
      perf_blocks <= 32'd0;
      perf_stall  <= 16'd0;
    end else begin
      if (out_acc) begin
        perf_blocks <= perf_blocks + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stall != 16'hFFFF)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Self-checking bench for aes_dec_round_ctrl (NUM_ROUNDS=10, KEXP_TIMEOUT=64).
// Expected waveforms are derived from the block-level schedule: a block
// accepted at T0 sees INIT at T0+1, rounds at T0+2..T0+NR, FINAL at T0+NR+1,
// then out_valid until the consumer accepts. Key loads are modelled as a
// KEXP window that closes on kexp_done or after KEXP_TIMEOUT cycles.

module tb_aes_dec_round_ctrl;
  localparam int unsigned NR = 10;
  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0, kexp_done = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       key_ready, kexp_start, kexp_err, in_ready;
  logic       dp_load_init, dp_round_en, dp_final_en, out_valid, busy;
  logic [3:0] rc, key_idx;
`ifdef AES_DEC_PERF_COUNT_EN
  logic [31:0] perf_blocks;
  logic [15:0] perf_stall;
`endif

  aes_dec_round_ctrl #(
    .NUM_ROUNDS  (NR),
    .KEXP_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .kexp_start  (kexp_start),
    .kexp_done   (kexp_done),
    .kexp_err    (kexp_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dp_load_init(dp_load_init),
    .dp_round_en (dp_round_en),
    .dp_final_en (dp_final_en),
    .rc          (rc),
    .key_idx     (key_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef AES_DEC_PERF_COUNT_EN
    ,
    .perf_blocks (perf_blocks),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state.
  bit loaded  = 1'b0;
  bit exp_err = 1'b0;
  int exp_blocks = 0;
  int exp_stall  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {load_init, round_en, final_en, out_valid, busy, key_ready, in_ready}
  function automatic logic [6:0] flags();
    return {dp_load_init, dp_round_en, dp_final_en, out_valid, busy, key_ready, in_ready};
  endfunction

  task automatic check_perf(input string tag);
`ifdef AES_DEC_PERF_COUNT_EN
    check({tag, "_perf_blocks"}, perf_blocks, 32'(exp_blocks));
    check({tag, "_perf_stall"}, {16'd0, perf_stall}, 32'(exp_stall));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, {25'd0, flags()}, 32'd0);
    check({tag, "_rc_kidx"}, {24'd0, rc, key_idx}, 32'd0);
    check({tag, "_start_err"}, {30'd0, kexp_start, kexp_err}, 32'd0);
  endtask

  // Idle without a usable key: blocks must be refused.
  task automatic check_locked(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      #1;
      check("locked_flags", {25'd0, flags()}, 32'b0000010);
      check("locked_err", {31'd0, kexp_err}, {31'd0, exp_err});
    end
  endtask

  // delay: KEXP cycle index (0 = the kexp_start cycle) at which kexp_done pulses;
  // anything outside 0..TO-1 means it never comes.
  task automatic load_key(input int delay, input bit with_blk);
    bit timed_out;
    @(negedge clk);
    key_valid = 1'b1;
    in_valid  = with_blk;
    out_ready = 1'b0;
    kexp_done = 1'b0;
    #1;
    check("key_ready_idle", {31'd0, key_ready}, 32'd1);
    check("in_ready_key_prio", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    key_valid = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < int'(TO); k++) begin
      kexp_done = (k == delay);
      #1;
      check($sformatf("kexp_start_c%0d", k), {31'd0, kexp_start}, {31'd0, (k == 0)});
      check($sformatf("kexp_flags_c%0d", k), {25'd0, flags()}, 32'b0000100);
      check("kexp_err_cleared", {31'd0, kexp_err}, 32'd0);
      if (k == delay) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!timed_out) @(negedge clk);
    kexp_done = 1'b0;
    in_valid  = 1'b0;
    #1;
    loaded     = !timed_out;
    exp_err    = timed_out;
    exp_blocks = 0;
    exp_stall  = 0;
    check("kexp_exit_flags", {25'd0, flags()}, {30'd0, 1'b1, loaded});
    check("kexp_exit_err", {31'd0, kexp_err}, {31'd0, exp_err});
    check_perf("kexp_exit");
  endtask

  task automatic run_block(input int stall);
    logic [6:0] e;
    logic [3:0] rc_e, ki_e;
    @(negedge clk);
    key_valid = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    check("blk_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k <= int'(NR) + 1; k++) begin
      @(negedge clk);
      // Noise on the handshakes must be ignored while busy.
      key_valid = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      e    = 7'b0000100;
      rc_e = 4'd0;
      ki_e = 4'd0;
      if (k == 1) begin
        e[6] = 1'b1;
        ki_e = 4'(NR - 1);
      end else if (k <= int'(NR)) begin
        e[5] = 1'b1;
        rc_e = 4'(int'(NR) + 1 - k);
        ki_e = 4'(int'(NR) - k);
      end else begin
        e[4] = 1'b1;
        ki_e = 4'(NR - 1);
      end
      check($sformatf("blk_flags_t%0d", k), {25'd0, flags()}, {25'd0, e});
      check($sformatf("blk_rc_t%0d", k), {28'd0, rc}, {28'd0, rc_e});
      check($sformatf("blk_kidx_t%0d", k), {28'd0, key_idx}, {28'd0, ki_e});
    end
    for (int w = 0; w <= stall; w++) begin
      @(negedge clk);
      key_valid = 1'b0;
      in_valid  = 1'b0;
      out_ready = (w == stall);
      #1;
      check($sformatf("outv_flags_w%0d", w), {25'd0, flags()}, 32'b0001100);
      check("outv_rc_kidx", {24'd0, rc, key_idx}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    exp_blocks++;
    exp_stall += stall;
    check("post_blk_flags", {25'd0, flags()}, 32'b0000011);
    check("post_blk_err", {31'd0, kexp_err}, {31'd0, exp_err});
    check_perf("post_blk");
  endtask

  // Accept a block, then hit reset asynchronously in cycle T0+at.
  task automatic abort_block(input int at);
    @(negedge clk);
    in_valid  = 1'b1;
    key_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (at) @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_zero("abort_async");
    @(negedge clk);
    #1;
    check_zero("abort_held");
    @(negedge clk);
    reset = 1'b0;
    #1;
    loaded     = 1'b0;
    exp_err    = 1'b0;
    exp_blocks = 0;
    exp_stall  = 0;
    check_zero("abort_release");
    check_locked(4);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("reset_release");
    check_locked(2);

    load_key(5, 1'b0);
    run_block(0);
    run_block(4);
    load_key(int'($urandom_range(0, 10)), 1'b1);
    run_block(1);
    load_key(-1, 1'b0);
    check_locked(3);
    load_key(int'(TO) - 1, 1'b0);  // done and timeout coincide
    run_block(2);
    abort_block(6);
    load_key(0, 1'b0);
    run_block(0);

    for (int i = 0; i < 25; i++) begin
      if (!loaded) begin
        check_locked(1);
        load_key(int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 3) == 0) begin
        load_key(int'($urandom_range(0, 70)), 1'($urandom_range(0, 1)));
      end else begin
        run_block(int'($urandom_range(0, 5)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
